// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson (twisted-ring) code checker.
package johnson_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Number of distinct codes in a WIDTH-bit Johnson sequence.
  function automatic int seq_len(input int width);
    return 2 * width;
  endfunction

  // Legal Johnson codes have at most one boundary between a run of ones and a run of zeros.
  function automatic bit johnson_is_legal(input logic [31:0] code, input int width);
    int flips;
    flips = 0;
    for (int i = 1; i < width; i++) begin
      if (code[i] != code[i-1]) flips++;
    end
    return (flips <= 1);
  endfunction

  // Fill phase (ones entering from the MSB) maps to popcount; drain phase maps to SEQ - popcount.
  // Illegal codes go through the same arithmetic, so their index is deterministic.
  function automatic int johnson_to_idx(input logic [31:0] code, input int width);
    int pc;
    pc = 0;
    for (int i = 0; i < width; i++) begin
      pc += int'(code[i]);
    end
    if (pc == 0 || code[width-1]) return pc;
    return 2 * width - pc;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decode of a Johnson code into its sequence index and a legality flag.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic [IDX_W-1:0] idx,
  output logic             legal
);

  // Pure table-free decode; both outputs follow the input directly.
  always_comb begin
    legal = johnson_is_legal(32'(code), WIDTH);
    idx   = IDX_W'(johnson_to_idx(32'(code), WIDTH));
  end

endmodule

// File: rtl/johnson_seq_checker.sv
// Receive-side monitor for a Johnson counter bus: decodes each sample, flags illegal
// codes and transitions, tracks lock, and counts errors with saturation.
//
// state  | meaning
// HUNT   | acquiring: counting consecutive good transitions, only illegal codes raise step_err
// LOCKED | tracking: any illegal code or broken transition raises step_err and drops to HUNT
module johnson_seq_checker
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8,
  localparam int SEQ     = seq_len(WIDTH),
  localparam int IDX_W   = $clog2(SEQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] code,
  input  logic             step,
  input  logic             exp_clr,
  output logic [IDX_W-1:0] idx,
  output logic             code_legal,
  output logic             step_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] exp_idx;
  logic             cur_legal;
  logic             prev_step;
  logic             prev_clr;
  logic             have_prev;
  logic             checked;
  logic             expect_ok;
  logic             good;
  logic             bad;
  logic             err_pulse;
  lock_state_t      state;
  lock_state_t      state_nxt;
  logic [3:0]       good_cnt;
  logic [3:0]       good_nxt;

  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .code  (code),
    .idx   (cur_idx),
    .legal (cur_legal)
  );

  // Compare this sample against what the previous sample's qualifiers promised.
  // idx/code_legal double as the previous sample's decode.
  always_comb begin
    exp_idx = idx;
    if (prev_step) exp_idx = (idx == IDX_W'(SEQ - 1)) ? '0 : idx + IDX_W'(1);
    // A clear promise is honoured even after an illegal code; other promises need a legal predecessor.
    checked   = have_prev && (prev_clr || code_legal);
    expect_ok = prev_clr ? (code == '0) : (cur_idx == exp_idx);
    good      = cur_legal && checked && expect_ok;
    bad       = !cur_legal || (checked && !expect_ok);
  end

  // Lock FSM next-state and error pulse.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_pulse = 1'b0;
    case (state)
      HUNT: begin
        err_pulse = !cur_legal;
        if (good) begin
          if (good_cnt + 4'd1 == 4'(LOCK_CNT)) begin
            state_nxt = LOCKED;
            good_nxt  = '0;
          end else begin
            good_nxt = good_cnt + 4'd1;
          end
        end else begin
          good_nxt = '0;
        end
      end
      LOCKED: begin
        if (bad) begin
          err_pulse = 1'b1;
          state_nxt = HUNT;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = HUNT;
        good_nxt  = '0;
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  // Sample pipeline: decoded code plus the qualifiers that set the next expectation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      code_legal <= 1'b0;
      prev_step  <= 1'b0;
      prev_clr   <= 1'b0;
      have_prev  <= 1'b0;
    end else begin
      idx        <= cur_idx;
      code_legal <= cur_legal;
      prev_step  <= step;
      prev_clr   <= exp_clr;
      have_prev  <= 1'b1;
    end
  end

  // Error pulse and saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_err  <= 1'b0;
      err_count <= '0;
    end else begin
      step_err <= err_pulse;
      if (err_pulse && err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_seq_checker.sv
// Scoreboard bench for johnson_seq_checker (WIDTH=4, LOCK_CNT=2, ERR_W=8).
module tb_johnson_seq_checker;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 2;
  localparam int ERR_W    = 8;
  localparam int SEQ      = 2 * WIDTH;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] code;
  logic             step;
  logic             exp_clr;
  logic [2:0]       idx;
  logic             code_legal;
  logic             step_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  johnson_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .code       (code),
    .step       (step),
    .exp_clr    (exp_clr),
    .idx        (idx),
    .code_legal (code_legal),
    .step_err   (step_err),
    .locked     (locked),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit legal;
    bit serr;
    bit lck;
    int errc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // Reference: the Johnson sequence as an explicit table of codes.
  logic [WIDTH-1:0] tab[SEQ];

  // Reference model state (spec-level view).
  bit m_have_prev, m_prev_legal, m_prev_step, m_prev_clr, m_locked;
  int m_prev_pos, m_good, m_err;
  logic [WIDTH-1:0] last_code;
  bit last_step, last_clr;

  function automatic int find_pos(input logic [WIDTH-1:0] c);
    for (int i = 0; i < SEQ; i++) if (tab[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] rand_illegal();
    logic [WIDTH-1:0] c;
    c = 4'b1010;
    for (int t = 0; t < 64; t++) begin
      c = WIDTH'($urandom);
      if (find_pos(c) < 0) return c;
    end
    return 4'b0100;
  endfunction

  task automatic model_reset();
    m_have_prev = 0; m_prev_legal = 0; m_prev_step = 0; m_prev_clr = 0;
    m_locked = 0; m_prev_pos = 0; m_good = 0; m_err = 0;
  endtask

  // Predict the outputs produced by sampling (c, s, clr) at the next rising edge.
  task automatic model_sample(input logic [WIDTH-1:0] c, input bit s, input bit clr);
    int pos, pc, e_idx;
    bit legal, checked, ok, bad, pulse;
    exp_t e;
    pos   = find_pos(c);
    legal = (pos >= 0);
    pc    = $countones(c);
    if (legal) e_idx = pos;
    else if (c == 0 || c[WIDTH-1]) e_idx = pc;
    else e_idx = SEQ - pc;
    checked = m_have_prev && (m_prev_clr || m_prev_legal);
    if (m_prev_clr) ok = (c == 0);
    else if (m_prev_step) ok = (c == tab[(m_prev_pos + 1) % SEQ]);
    else ok = (c == tab[m_prev_pos]);
    bad   = !legal || (checked && !ok);
    pulse = m_locked ? bad : !legal;
    if (m_locked) begin
      if (bad) begin m_locked = 0; m_good = 0; end
    end else if (legal && checked && ok) begin
      m_good++;
      if (m_good == LOCK_CNT) begin m_locked = 1; m_good = 0; end
    end else begin
      m_good = 0;
    end
    if (pulse && m_err < ERR_MAX) m_err++;
    m_have_prev = 1; m_prev_legal = legal; m_prev_pos = legal ? pos : 0;
    m_prev_step = s; m_prev_clr = clr;
    e.idx = e_idx; e.legal = legal; e.serr = pulse; e.lck = m_locked; e.errc = m_err;
    q.push_back(e);
  endtask

  // Drive one sample (at a falling edge), predict it, then wait for the next falling edge.
  task automatic drive(input logic [WIDTH-1:0] c, input bit s, input bit clr);
    code = c; step = s; exp_clr = clr;
    last_code = c; last_step = s; last_clr = clr;
    model_sample(c, s, clr);
    @(negedge clk);
  endtask

  task automatic drive_pos(input int p, input bit s, input bit clr);
    drive(tab[p], s, clr);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (idx != 0 || code_legal || step_err || locked || err_count != 0) begin
      errors++;
      $display("FAIL %s: got idx=%0d legal=%0b step_err=%0b locked=%0b err_count=%0d, want all zero",
               name, idx, code_legal, step_err, locked, err_count);
    end
  endtask

  // Monitor: every post-reset edge presents one registered result; pop and compare.
  always @(posedge clk) begin
    #1;
    if (!rst && q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (int'(idx) != mon_e.idx || code_legal != mon_e.legal || step_err != mon_e.serr ||
          locked != mon_e.lck || int'(err_count) != mon_e.errc) begin
        errors++;
        $display("FAIL sample @%0t: got idx=%0d legal=%0b step_err=%0b locked=%0b err_count=%0d, want idx=%0d legal=%0b step_err=%0b locked=%0b err_count=%0d",
                 $time, idx, code_legal, step_err, locked, err_count,
                 mon_e.idx, mon_e.legal, mon_e.serr, mon_e.lck, mon_e.errc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int lpos;
    int r;
    logic [WIDTH-1:0] nc;
    tab[0] = '0;
    for (int i = 1; i < SEQ; i++) tab[i] = {~tab[i-1][0], tab[i-1][WIDTH-1:1]};
    model_reset();
    rst = 1'b1; code = '0; step = 1'b0; exp_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    // Full ring with wrap back to 0000.
    for (int p = 0; p < SEQ; p++) drive_pos(p, 1, 0);
    drive_pos(0, 1, 0);

    // Hold at 1110 for three cycles.
    drive_pos(1, 1, 0); drive_pos(2, 1, 0);
    repeat (3) drive_pos(3, 0, 0);
    drive_pos(3, 1, 0);

    // Skip 1100 -> 1111 while locked, then relock.
    for (int p = 4; p < SEQ; p++) drive_pos(p, 1, 0);
    drive_pos(0, 1, 0); drive_pos(1, 1, 0); drive_pos(2, 1, 0);
    drive_pos(4, 1, 0);
    drive_pos(5, 1, 0); drive_pos(6, 1, 0); drive_pos(7, 1, 0);

    // Illegal code, then a legal code that only restarts tracking.
    drive(4'b1010, 1, 0);
    drive_pos(6, 1, 0); drive_pos(7, 1, 0); drive_pos(0, 1, 0); drive_pos(1, 1, 0);

    // Clear honoured, then clear violated while locked.
    drive_pos(2, 1, 0); drive_pos(3, 1, 0); drive_pos(4, 1, 0);
    drive_pos(5, 1, 1); drive_pos(0, 1, 0);
    for (int p = 1; p <= 4; p++) drive_pos(p, 1, 0);
    drive_pos(5, 1, 1); drive_pos(1, 1, 0);
    drive_pos(2, 1, 0); drive_pos(3, 1, 0);

    // Randomised mostly-following traffic with occasional faults.
    for (int n = 0; n < 250; n++) begin
      lpos = find_pos(last_code);
      if (last_clr) nc = '0;
      else if (lpos < 0) nc = tab[$urandom_range(0, SEQ - 1)];
      else if (last_step) nc = tab[(lpos + 1) % SEQ];
      else nc = tab[lpos];
      r = $urandom_range(0, 99);
      if (r < 5) nc = rand_illegal();
      else if (r < 10) nc = tab[$urandom_range(0, SEQ - 1)];
      drive(nc, 1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
    end

    // Saturate the error counter.
    for (int n = 0; n < 300; n++) drive(rand_illegal(), 1'($urandom_range(0, 1)), 1'b0);

    // Asynchronous reset away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    check_zero("reset_held");
    model_reset();
    rst = 1'b0;
    for (int p = 0; p < 5; p++) drive_pos(p, 1, 0);

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked samples, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
